music_stream_ctrl: RTL and testbench

- Playback sequencer for the registered music sample ROM: 17-bit address in, 17-bit sample out, one-cycle read latency.
- Generates one sample request per sample period. Walks the ROM address from START_ADDR to END_ADDR and presents each sample to the audio output path over a valid/ready handshake.
- Implements play, pause, stop and loop control, and counts sample periods missed because the output side stalled.
- Sits between the game-state logic, which issues play/pause/stop, and the audio codec interface.

---
 rtl/music_stream_ctrl.sv | 168 ++++++++++++++++
 tb/tb_music_stream_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/music_stream_ctrl.sv
// Music ROM playback sequencer: one ROM read per sample period, valid/ready
// presentation to the audio path, play/pause/stop/loop control and a missed-period counter.
module music_stream_ctrl #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 17,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 43113,
  parameter int CLK_DIV    = 1134
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              playing,
  output logic              done,
  output logic [7:0]        miss_count
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDR);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    READ      = 3'd2,
    LATCH     = 3'd3,
    PRESENT   = 3'd4,
    PAUSED    = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t              state_r, next_state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   sample_r;
  logic                valid_r, pend_r, playing_r, done_r;
  logic [7:0]          miss_r;
  logic                run_s, busy_s, tick_s, handshake_s, at_end_s, resume_s, next_run_s;

  assign rom_addr     = addr_r;
  assign sample       = sample_r;
  assign sample_valid = valid_r;
  assign playing      = playing_r;
  assign done         = done_r;
  assign miss_count   = miss_r;

  // Status decode shared by the counter, datapath and next-state logic
  always_comb begin
    run_s       = (state_r == WAIT_TICK) || (state_r == READ) ||
                  (state_r == LATCH)     || (state_r == PRESENT);
    busy_s      = (state_r == READ) || (state_r == LATCH) || (state_r == PRESENT);
    tick_s      = run_s && (cnt_r == TICK_LAST);
    handshake_s = (state_r == PRESENT) && sample_ready;
    at_end_s    = (addr_r == END_A);
    resume_s    = !run_s && (next_state_s == WAIT_TICK);
    next_run_s  = (next_state_s == WAIT_TICK) || (next_state_s == READ) ||
                  (next_state_s == LATCH)     || (next_state_s == PRESENT);
  end

  // Next-state logic; stop overrides everything, pause overrides play
  always_comb begin
    next_state_s = state_r;
    if (stop) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, PAUSED, DONE: begin
          if (play && !pause) next_state_s = WAIT_TICK;
          else                next_state_s = state_r;
        end
        WAIT_TICK: begin
          if (pause)       next_state_s = PAUSED;
          else if (tick_s) next_state_s = READ;
          else             next_state_s = WAIT_TICK;
        end
        READ:  next_state_s = LATCH;
        LATCH: next_state_s = PRESENT;
        PRESENT: begin
          if (!sample_ready)            next_state_s = PRESENT;
          else if (at_end_s && !loop_en) next_state_s = DONE;
          else if (pend_r || pause)     next_state_s = PAUSED;
          else                          next_state_s = WAIT_TICK;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= next_state_s;
  end

  // Sample-period counter: restarts whenever playback (re)starts
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)               cnt_r <= '0;
    else if (stop || resume_s)  cnt_r <= '0;
    else if (run_s)             cnt_r <= tick_s ? '0 : cnt_r + CNT_W'(1);
    else                        cnt_r <= cnt_r;
  end

  // Missed periods: a tick while the previous sample is still in flight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                               miss_r <= 8'd0;
    else if (tick_s && busy_s && miss_r != 8'hFF) miss_r <= miss_r + 8'd1;
    else                                        miss_r <= miss_r;
  end

  // ROM address walk and deferred pause request
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_r <= START_A;
      pend_r <= 1'b0;
    end else if (stop) begin
      addr_r <= START_A;
      pend_r <= 1'b0;
    end else begin
      if (state_r == DONE && resume_s)          addr_r <= START_A;
      else if (handshake_s && !(at_end_s && !loop_en))
        addr_r <= at_end_s ? START_A : addr_r + ADDR_W'(1);
      else                                      addr_r <= addr_r;
      if (busy_s) pend_r <= handshake_s ? 1'b0 : (pend_r | pause);
      else        pend_r <= 1'b0;
    end
  end

  // Sample capture and valid flag; ROM data arrives in LATCH
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sample_r <= '0;
      valid_r  <= 1'b0;
    end else if (stop) begin
      sample_r <= sample_r;
      valid_r  <= 1'b0;
    end else if (state_r == LATCH) begin
      sample_r <= rom_data;
      valid_r  <= 1'b1;
    end else if (handshake_s) begin
      sample_r <= sample_r;
      valid_r  <= 1'b0;
    end else begin
      sample_r <= sample_r;
      valid_r  <= valid_r;
    end
  end

  // Registered status flags track the state being entered
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      playing_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      playing_r <= next_run_s;
      done_r    <= (next_state_s == DONE);
    end
  end

endmodule

// File: tb/tb_music_stream_ctrl.sv
// Self-checking bench for music_stream_ctrl: directed scenarios plus random
// control traffic, every cycle compared against a behavioural playback model.
module tb_music_stream_ctrl;

  localparam int DIV   = 4;
  localparam int END_A = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic        sample_ready = 1'b0;
  logic [16:0] rom_addr, rom_data, sample;
  logic        sample_valid, playing, done;
  logic [7:0]  miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode, position in the read pipeline since the last accepted tick
  // (0 waiting, 1..3 read/latch/present), running-cycle count since start.
  int          m_mode, m_phase, m_tcount, m_miss;
  logic [16:0] m_addr, m_sample;
  bit          m_valid, m_pend;
  logic [16:0] hs_q[$];

  music_stream_ctrl #(.ADDR_W(17), .DATA_W(17), .START_ADDR(0), .END_ADDR(END_A), .CLK_DIV(DIV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .play(play), .pause(pause), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .playing(playing), .done(done), .miss_count(miss_count));

  always #5 Clk = ~Clk;

  function automatic logic [16:0] rom_val(input logic [16:0] a);
    return 17'h10 + a;
  endfunction

  always_ff @(posedge Clk) rom_data <= rom_val(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_tcount = 0; m_miss = 0;
    m_addr = 17'd0; m_sample = 17'd0; m_valid = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_step(input bit pl, input bit pa, input bit st, input bit rd, input bit lp);
    bit tick, want_pause;
    tick = (m_mode == M_RUN) && ((m_tcount % DIV) == DIV - 1);
    if (tick && m_phase != 0 && m_miss < 255) m_miss++;
    if (st) begin
      m_mode = M_IDLE; m_addr = 17'd0; m_valid = 1'b0; m_pend = 1'b0; m_phase = 0; m_tcount = 0;
    end else if (m_mode != M_RUN) begin
      if (pl && !pa) begin
        if (m_mode == M_DONE) m_addr = 17'd0;
        m_mode = M_RUN; m_phase = 0; m_tcount = 0;
      end
    end else begin
      m_tcount++;
      case (m_phase)
        0: begin
          if (pa) m_mode = M_PAUSED;
          else if (tick) m_phase = 1;
        end
        1: begin m_pend = m_pend | pa; m_phase = 2; end
        2: begin m_pend = m_pend | pa; m_sample = rom_val(m_addr); m_valid = 1'b1; m_phase = 3; end
        default: begin
          want_pause = m_pend | pa;
          if (rd) begin
            m_valid = 1'b0; m_phase = 0; m_pend = 1'b0;
            if (m_addr == END_A && !lp) m_mode = M_DONE;
            else begin
              m_addr = (m_addr == END_A) ? 17'd0 : m_addr + 17'd1;
              if (want_pause) m_mode = M_PAUSED;
            end
          end else m_pend = want_pause;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("sample", 32'(sample), 32'(m_sample));
    chk("playing", 32'(playing), 32'(m_mode == M_RUN));
    chk("done", 32'(done), 32'(m_mode == M_DONE));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
  endtask

  // One clock: drive inputs at negedge, model the edge, check at next negedge
  task automatic step(input bit pl, input bit pa, input bit st, input bit rd);
    play = pl; pause = pa; stop = st; sample_ready = rd;
    if (sample_valid && rd) hs_q.push_back(sample);
    @(posedge Clk);
    model_step(pl, pa, st, rd, loop_en);
    @(negedge Clk);
    check_all();
    play = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  initial begin
    bit found;
    bit pl, pa, st, rd;
    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    Reset_n = 1'b1;

    // Single pass, no loop
    hs_q.delete();
    step(1, 0, 0, 1);
    repeat (24) step(0, 0, 0, 1);
    chk("t1_count", 32'(hs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (hs_q.size() > i) chk("t1_seq", 32'(hs_q[i]), 32'(17'h10 + 17'(i)));
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_miss", 32'(miss_count), 32'd0);

    // Looping
    step(0, 0, 1, 1);
    loop_en = 1'b1;
    hs_q.delete();
    step(1, 0, 0, 1);
    repeat (30) step(0, 0, 0, 1);
    chk("t2_count", 32'(hs_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (hs_q.size() > i) chk("t2_seq", 32'(hs_q[i]), 32'(17'h10 + 17'(i % 4)));
    chk("t2_done", 32'(done), 32'd0);

    // Output stall on the first sample
    step(0, 0, 1, 1);
    loop_en = 1'b0;
    hs_q.delete();
    step(1, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0);
      found = sample_valid;
    end
    chk("t3_reach", 32'(found), 32'd1);
    repeat (10) step(0, 0, 0, 0);
    chk("t3_hold_sample", 32'(sample), 32'h10);
    chk("t3_hold_valid", 32'(sample_valid), 32'd1);
    repeat (10) step(0, 0, 0, 1);
    chk("t3_miss", 32'(miss_count), 32'd3);
    if (hs_q.size() > 1) begin
      chk("t3_first", 32'(hs_q[0]), 32'h10);
      chk("t3_second", 32'(hs_q[1]), 32'h11);
    end else chk("t3_count", 32'(hs_q.size()), 32'd2);

    // Pause during PRESENT of 0x11
    step(0, 0, 1, 1);
    step(1, 0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 0, 0, 1);
      found = sample_valid && (sample == 17'h11);
    end
    chk("t4_reach", 32'(found), 32'd1);
    step(0, 1, 0, 1);
    chk("t4_addr", 32'(rom_addr), 32'd2);
    chk("t4_playing", 32'(playing), 32'd0);
    hs_q.delete();
    repeat (20) step(0, 0, 0, 1);
    chk("t4_quiet", 32'(hs_q.size()), 32'd0);
    step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 1);
    chk("t4_not_yet", 32'(sample_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("t4_valid", 32'(sample_valid), 32'd1);
    chk("t4_sample", 32'(sample), 32'h12);

    // Stop during READ at address 2
    step(0, 0, 1, 1);
    step(1, 0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 0, 0, 1);
      found = (m_mode == M_RUN) && (m_phase == 1) && (m_addr == 17'd2);
    end
    chk("t5_reach", 32'(found), 32'd1);
    step(0, 0, 1, 1);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    chk("t5_valid", 32'(sample_valid), 32'd0);
    chk("t5_playing", 32'(playing), 32'd0);
    hs_q.delete();
    step(1, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);
    if (hs_q.size() > 0) chk("t5_first", 32'(hs_q[0]), 32'h10);
    else chk("t5_count", 32'(hs_q.size()), 32'd1);

    // Miss counter saturation, not cleared by stop
    step(0, 0, 1, 1);
    step(1, 0, 0, 0);
    repeat (1100) step(0, 0, 0, 0);
    chk("t6_sat", 32'(miss_count), 32'd255);
    step(0, 0, 1, 1);
    chk("t6_keep", 32'(miss_count), 32'd255);

    // Asynchronous reset in PRESENT
    step(1, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0);
      found = sample_valid;
    end
    chk("t7_reach", 32'(found), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("t7_addr", 32'(rom_addr), 32'd0);
    chk("t7_valid", 32'(sample_valid), 32'd0);
    chk("t7_sample", 32'(sample), 32'd0);
    chk("t7_playing", 32'(playing), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_miss", 32'(miss_count), 32'd0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;

    // Simultaneous stop/pause/play while running
    step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    chk("t8_playing", 32'(playing), 32'd0);
    chk("t8_addr", 32'(rom_addr), 32'd0);
    chk("t8_valid", 32'(sample_valid), 32'd0);

    // Random control and back-pressure traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) loop_en = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) != 0);
      pl = ($urandom_range(0, 9) == 0);
      pa = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 79) == 0);
      step(pl, pa, st, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
